rle_block_decoder: RTL and testbench

Decode side of the luma pipeline. Takes run-length (value, count) pairs in zig-zag order and expands each run into individual coefficients. It writes each coefficient into an 8x8 block buffer at its natural (raster) position through a zig-zag-to-raster lookup. When all 64 coefficients are written, it streams them out in raster order over a valid/ready handshake, ready for the inverse-DCT stage.

---
 rtl/rle_block_decoder.sv | 164 ++++++++++++++++
 tb/tb_rle_block_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_block_decoder.sv
// Run-length block decoder: expands zig-zag (value, count) pairs into an 8x8 block buffer and
// streams it out in raster order. Define RLE_EOB_ZERO_FILL_EN to zero-fill a block ended by s_last.
module rle_block_decoder #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned COUNT_WIDTH = 7
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_value,
  input  logic [COUNT_WIDTH-1:0]       s_count,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic                         err_out
);

  typedef enum logic [1:0] {StFill, StRun, StEmit, StZfill} state_e;

  // Zig-zag scan index -> raster index (standard JPEG order).
  localparam logic [5:0] Zz2Nat [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_e                         state_q;
  logic [5:0]                     zz_idx_q;
  logic [5:0]                     rd_idx_q;
  logic [5:0]                     rd_next;
  logic [COUNT_WIDTH-1:0]         rem_q;
  logic signed [DATA_WIDTH-1:0]   run_val_q;
  logic                           clr_pend_q;
  logic signed [DATA_WIDTH-1:0]   blk_mem [64];
  logic                           wr_en;
  logic signed [DATA_WIDTH-1:0]   wr_data;

`ifdef RLE_EOB_ZERO_FILL_EN
  logic last_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif

  assign rd_next = rd_idx_q + 6'd1;

  always_comb begin
    wr_en   = 1'b0;
    wr_data = run_val_q;
    if (state_q == StRun) wr_en = 1'b1;
`ifdef RLE_EOB_ZERO_FILL_EN
    if (state_q == StZfill) begin
      wr_en   = 1'b1;
      wr_data = '0;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) blk_mem[Zz2Nat[zz_idx_q]] <= wr_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StFill;
      zz_idx_q   <= '0;
      rd_idx_q   <= '0;
      rem_q      <= '0;
      run_val_q  <= '0;
      clr_pend_q <= 1'b0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= '0;
      err_out    <= 1'b0;
`ifdef RLE_EOB_ZERO_FILL_EN
      last_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFill: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            run_val_q  <= s_value;
            rem_q      <= s_count;
            clr_pend_q <= 1'b0;
            // The post-EMIT clear and a new zero-count error both land in this cycle.
            err_out    <= (err_out && !clr_pend_q) || (s_count == '0);
`ifdef RLE_EOB_ZERO_FILL_EN
            last_q     <= s_last;
`endif
            if (s_count != '0) begin
              state_q <= StRun;
              s_ready <= 1'b0;
            end
          end
        end
        StRun: begin
          zz_idx_q <= zz_idx_q + 6'd1;
          rem_q    <= rem_q - COUNT_WIDTH'(1);
          if (zz_idx_q == 6'd63) begin
            // Block full; any leftover run length is an overrun and is dropped.
            state_q  <= StEmit;
            zz_idx_q <= '0;
            rd_idx_q <= '0;
            m_valid  <= 1'b1;
            m_data   <= blk_mem[0];
            m_last   <= 1'b0;
            if (rem_q > COUNT_WIDTH'(1)) err_out <= 1'b1;
          end else if (rem_q == COUNT_WIDTH'(1)) begin
`ifdef RLE_EOB_ZERO_FILL_EN
            if (last_q) begin
              state_q <= StZfill;
            end else begin
              state_q <= StFill;
              s_ready <= 1'b1;
            end
`else
            state_q <= StFill;
            s_ready <= 1'b1;
`endif
          end
        end
        StZfill: begin
          zz_idx_q <= zz_idx_q + 6'd1;
          if (zz_idx_q == 6'd63) begin
            state_q  <= StEmit;
            zz_idx_q <= '0;
            rd_idx_q <= '0;
            m_valid  <= 1'b1;
            m_data   <= blk_mem[0];
            m_last   <= 1'b0;
          end
        end
        StEmit: begin
          if (m_ready) begin
            if (rd_idx_q == 6'd63) begin
              state_q    <= StFill;
              rd_idx_q   <= '0;
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              s_ready    <= 1'b1;
              clr_pend_q <= 1'b1;
            end else begin
              rd_idx_q <= rd_next;
              m_data   <= blk_mem[rd_next];
              m_last   <= (rd_next == 6'd63);
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_block_decoder.sv
// Scoreboard bench for rle_block_decoder: directed run-length blocks, expected raster output
// derived from an independently generated zig-zag scan.
module tb_rle_block_decoder;
  localparam int DW = 11;
  localparam int CW = 7;

  logic                 clk_in  = 1'b0;
  logic                 rst_in  = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_last  = 1'b0;
  logic                 m_ready = 1'b0;
  logic signed [DW-1:0] s_value = '0;
  logic [CW-1:0]        s_count = '0;
  logic                 s_ready;
  logic                 m_valid;
  logic                 m_last;
  logic                 err_out;
  logic signed [DW-1:0] m_data;

  typedef struct packed {
    logic signed [DW-1:0] data;
    logic                 last;
  } exp_t;

  exp_t exp_q[$];
  int   pv[$];
  int   pc[$];
  int   nat_of[64];
  int   checks   = 0;
  int   failures = 0;
  int   xfers    = 0;
  logic tog_en   = 1'b0;

  always #5 clk_in = ~clk_in;

  rle_block_decoder #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_value (s_value),
    .s_count (s_count),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .err_out (err_out)
  );

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Zig-zag scan built by walking anti-diagonals of the 8x8 block.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int rlo = (s > 7) ? s - 7 : 0;
      int rhi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = rhi; r >= rlo; r--) begin nat_of[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = rlo; r <= rhi; r++) begin nat_of[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  task automatic push_expected();
    int   zz[64];
    int   ras[64];
    int   k = 0;
    exp_t e;
    for (int i = 0; i < 64; i++) zz[i] = 0;
    for (int p = 0; p < pv.size(); p++)
      for (int n = 0; n < pc[p] && k < 64; n++) begin zz[k] = pv[p]; k++; end
    for (int i = 0; i < 64; i++) ras[nat_of[i]] = zz[i];
    for (int r = 0; r < 64; r++) begin
      e.data = ras[r][DW-1:0];
      e.last = (r == 63);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_pair(input int v, input int c, input bit l);
    int t = 0;
    s_value = v[DW-1:0];
    s_count = c[CW-1:0];
    s_last  = l;
    s_valid = 1'b1;
    do begin @(negedge clk_in); t++; end while (!s_ready && t < 500);
    if (!s_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
    end
    @(posedge clk_in); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic issue_block();
    push_expected();
    for (int p = 0; p < pv.size(); p++) send_pair(pv[p], pc[p], 1'b0);
    pv.delete();
    pc.delete();
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk_in); t++; end
    chk({name, "_drain"}, exp_q.size(), 0);
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-stability under stall.
  initial begin
    logic                 stall_q = 1'b0;
    logic signed [DW-1:0] hold_d  = '0;
    logic                 hold_l  = 1'b0;
    exp_t                 e;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, hold_d);
          chk("stall_last", m_last, hold_l);
        end
        if (m_valid && m_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=%0d required=none", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e.data);
            chk("m_last", m_last, e.last);
          end
        end
        stall_q = m_valid && !m_ready;
        hold_d  = m_data;
        hold_l  = m_last;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_in); #1;
      if (tog_en) m_ready = ~m_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ready_bad;
    int x0;
    int vcnt;
    build_zz();
    m_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", err_out, 0);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("ready_after_reset", s_ready, 1);

    // 1: single 64-long run
    pv = '{5}; pc = '{64};
    issue_block();
    lat = 0; ready_bad = 0;
    while (!m_valid && lat < 200) begin
      @(negedge clk_in);
      if (!m_valid) begin lat++; if (s_ready) ready_bad++; end
    end
    chk("t1_latency", lat, 64);
    chk("t1_ready_low", ready_bad, 0);
    wait_drain("t1");
    chk("t1_err", err_out, 0);

    // 2: mixed short runs then a long zero run
    pv = '{1, 2, 3, 0}; pc = '{1, 1, 1, 61};
    issue_block();
    wait_drain("t2");
    chk("t2_err", err_out, 0);

    // 3: overrun
    pv = '{7, 9}; pc = '{60, 10};
    issue_block();
    vcnt = 0;
    while (!m_valid && vcnt < 200) begin @(negedge clk_in); vcnt++; end
    chk("t3_err_in_emit", err_out, 1);
    wait_drain("t3");
    chk("t3_err_held", err_out, 1);

    // 4: one coefficient per pair under toggling backpressure
    for (int k = 0; k < 64; k++) begin pv.push_back(k); pc.push_back(1); end
    x0 = xfers;
    push_expected();
    send_pair(pv[0], pc[0], 1'b0);
    chk("t4_err_cleared", err_out, 0);
    tog_en = 1'b1;
    for (int p = 1; p < 64; p++) send_pair(pv[p], pc[p], 1'b0);
    pv.delete(); pc.delete();
    wait_drain("t4");
    tog_en = 1'b0; m_ready = 1'b1;
    chk("t4_xfers", xfers - x0, 64);

    // 5: zero count, then reset mid-run
    pv = '{9, 4}; pc = '{0, 64};
    push_expected();
    send_pair(9, 0, 1'b0);
    chk("t5_err_cnt0", err_out, 1);
    send_pair(4, 64, 1'b0);
    pv.delete(); pc.delete();
    wait_drain("t5");
    chk("t5_err_held", err_out, 1);
    send_pair(8, 64, 1'b0);
    repeat (10) @(posedge clk_in);
    #1; rst_in = 1'b1; #1;
    chk("t5_rst_s_ready", s_ready, 0);
    chk("t5_rst_m_valid", m_valid, 0);
    chk("t5_rst_m_data", m_data, 0);
    chk("t5_rst_m_last", m_last, 0);
    chk("t5_rst_err", err_out, 0);
    @(negedge clk_in); rst_in = 1'b0;
    pv = '{6}; pc = '{64};
    issue_block();
    wait_drain("t5b");
    chk("t5b_err", err_out, 0);

    // 6: short block flagged with s_last
    pv = '{4, 0}; pc = '{3, 61};
    push_expected();
    send_pair(4, 3, 1'b1);
`ifndef RLE_EOB_ZERO_FILL_EN
    vcnt = 0;
    repeat (40) begin @(negedge clk_in); if (m_valid) vcnt++; end
    chk("t6_no_valid", vcnt, 0);
    send_pair(0, 61, 1'b0);
`endif
    pv.delete(); pc.delete();
    wait_drain("t6");
    chk("t6_err", err_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
